// File: rtl/aes_multiblock_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package : aes_multiblock_fsm_pkg
// Purpose : Shared types and constants for the multi-block AES control FSM:
//           state enum, key-length codes, error codes and round counts.
// Revision: 1.0 - initial release
// ============================================================================
package aes_multiblock_fsm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_STARTING = 3'd2,
    ST_WORKING  = 3'd3,
    ST_NEXT     = 3'd4,
    ST_FINISHED = 3'd5
  } aes_mb_state_t;

  localparam logic [1:0] KEY_128     = 2'd0;
  localparam logic [1:0] KEY_192     = 2'd1;
  localparam logic [1:0] KEY_256     = 2'd2;
  localparam logic [1:0] KEY_ILLEGAL = 2'd3;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_KEY_LEN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  localparam logic [3:0] ROUNDS_NONE = 4'd0;
  localparam logic [3:0] ROUNDS_128  = 4'd10;
  localparam logic [3:0] ROUNDS_192  = 4'd12;
  localparam logic [3:0] ROUNDS_256  = 4'd14;

  // Round count for a key-length code; the illegal code maps to 0.
  function automatic logic [3:0] key_rounds(input logic [1:0] key_len);
    logic [3:0] r;
    case (key_len)
      KEY_128: r = ROUNDS_128;
      KEY_192: r = ROUNDS_192;
      KEY_256: r = ROUNDS_256;
      default: r = ROUNDS_NONE;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : aes_watchdog
// Purpose : Free-running watchdog for one engine block. Counts while enabled,
//           restarts from zero on request and flags expiry at all-ones.
// Ports   : clk, reset_n (async, active-low), clear_i (sync soft clear),
//           restart_i (force count to 0), enable_i (count this cycle),
//           expired_o (count has reached 2^TMO_W-1)
// Revision: 1.0 - initial release
// ============================================================================
module aes_watchdog #(
  parameter int TMO_W = 12
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_i,
  input  logic restart_i,
  input  logic enable_i,
  output logic expired_o
);

  logic [TMO_W-1:0] cnt_q;
  logic [TMO_W-1:0] cnt_d;

  assign expired_o = &cnt_q;

  // Saturates at all-ones so an enabled-but-ignored watchdog never wraps
  // back to a non-expired value.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (enable_i && !expired_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_multiblock_fsm.sv
`default_nettype none
// ============================================================================
// Module  : aes_multiblock_fsm
// Purpose : Control FSM for the AES HWPE. Runs a job of N consecutive
//           128-bit blocks: per block it requests source/sink streamers at
//           advancing base addresses, starts the engine and waits for the
//           engine's completion under a watchdog.
// Ports   : clk, reset_n (async active-low), clear (sync soft clear)
//           slave side : start_i, n_blocks_i, key_len_i, src_base_i,
//                        dst_base_i -> busy_o, done_o, error_o, blk_cnt_o
//           streamers  : src/snk_ready_i -> src/snk_req_o, src/dst_addr_o,
//                        line_len_o
//           engine     : eng_done_i -> eng_start_o, eng_enable_o,
//                        eng_clear_o, rounds_o
// Revision: 1.0 - initial release
// ============================================================================
module aes_multiblock_fsm
  import aes_multiblock_fsm_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int BLK_BYTES     = 16,
  parameter int WORDS_PER_BLK = 4,
  parameter int NBLK_W        = 16,
  parameter int TMO_W         = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              start_i,
  input  logic [NBLK_W-1:0] n_blocks_i,
  input  logic [1:0]        key_len_i,
  input  logic [ADDR_W-1:0] src_base_i,
  input  logic [ADDR_W-1:0] dst_base_i,
  input  logic              src_ready_i,
  input  logic              snk_ready_i,
  input  logic              eng_done_i,
  output logic              src_req_o,
  output logic              snk_req_o,
  output logic [ADDR_W-1:0] src_addr_o,
  output logic [ADDR_W-1:0] dst_addr_o,
  output logic [15:0]       line_len_o,
  output logic              eng_start_o,
  output logic              eng_enable_o,
  output logic              eng_clear_o,
  output logic [3:0]        rounds_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [1:0]        error_o,
  output logic [NBLK_W-1:0] blk_cnt_o
);

  aes_mb_state_t     state_q, state_d;
  logic [NBLK_W-1:0] n_blocks_q, n_blocks_d;
  logic              key_bad_q, key_bad_d;
  logic [3:0]        rounds_q, rounds_d;
  logic [ADDR_W-1:0] src_addr_q, src_addr_d;
  logic [ADDR_W-1:0] dst_addr_q, dst_addr_d;
  logic [NBLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [1:0]        error_q, error_d;

  logic              wd_restart;
  logic              wd_enable;
  logic              wd_expired;
  logic [NBLK_W-1:0] blk_inc;

  assign blk_inc = blk_cnt_q + 1'b1;

  aes_watchdog #(
    .TMO_W(TMO_W)
  ) u_watchdog (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear_i  (clear),
    .restart_i(wd_restart),
    .enable_i (wd_enable),
    .expired_o(wd_expired)
  );

  always_comb begin
    state_d      = state_q;
    n_blocks_d   = n_blocks_q;
    key_bad_d    = key_bad_q;
    rounds_d     = rounds_q;
    src_addr_d   = src_addr_q;
    dst_addr_d   = dst_addr_q;
    blk_cnt_d    = blk_cnt_q;
    error_d      = error_q;
    src_req_o    = 1'b0;
    snk_req_o    = 1'b0;
    eng_start_o  = 1'b0;
    eng_enable_o = 1'b0;
    eng_clear_o  = 1'b0;
    done_o       = 1'b0;
    wd_restart   = 1'b0;
    wd_enable    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        eng_clear_o = 1'b1;
        if (start_i) begin
          n_blocks_d = n_blocks_i;
          key_bad_d  = (key_len_i == KEY_ILLEGAL);
          rounds_d   = key_rounds(key_len_i);
          src_addr_d = src_base_i;
          dst_addr_d = dst_base_i;
          blk_cnt_d  = '0;
          error_d    = ERR_NONE;
          state_d    = ST_CHECK;
        end
      end

      ST_CHECK: begin
        if (key_bad_q) begin
          error_d = ERR_KEY_LEN;
          state_d = ST_FINISHED;
        end else if (n_blocks_q == '0) begin
          state_d = ST_FINISHED;
        end else begin
          state_d = ST_STARTING;
        end
      end

      ST_STARTING: begin
        src_req_o    = 1'b1;
        snk_req_o    = 1'b1;
        eng_start_o  = 1'b1;
        eng_enable_o = 1'b1;
        // Hold the watchdog at zero so it reads 0 on the first WORKING cycle.
        wd_restart   = 1'b1;
        if (src_ready_i && snk_ready_i) begin
          state_d = ST_WORKING;
        end
      end

      ST_WORKING: begin
        eng_enable_o = 1'b1;
        wd_enable    = 1'b1;
        // Completion is tested before expiry so a done on the timeout
        // cycle still counts as a good block.
        if (eng_done_i) begin
          blk_cnt_d = blk_inc;
          state_d   = (blk_inc == n_blocks_q) ? ST_FINISHED : ST_NEXT;
        end else if (wd_expired) begin
          error_d = ERR_TIMEOUT;
          state_d = ST_FINISHED;
        end
      end

      ST_NEXT: begin
        src_addr_d = src_addr_q + ADDR_W'(BLK_BYTES);
        dst_addr_d = dst_addr_q + ADDR_W'(BLK_BYTES);
        state_d    = ST_STARTING;
      end

      ST_FINISHED: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      n_blocks_q <= '0;
      key_bad_q  <= 1'b0;
      rounds_q   <= ROUNDS_NONE;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      blk_cnt_q  <= '0;
      error_q    <= ERR_NONE;
    end else if (clear) begin
      state_q    <= ST_IDLE;
      n_blocks_q <= '0;
      key_bad_q  <= 1'b0;
      rounds_q   <= ROUNDS_NONE;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      blk_cnt_q  <= '0;
      error_q    <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      n_blocks_q <= n_blocks_d;
      key_bad_q  <= key_bad_d;
      rounds_q   <= rounds_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      blk_cnt_q  <= blk_cnt_d;
      error_q    <= error_d;
    end
  end

  assign src_addr_o = src_addr_q;
  assign dst_addr_o = dst_addr_q;
  assign line_len_o = 16'(WORDS_PER_BLK);
  assign rounds_o   = rounds_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign error_o    = error_q;
  assign blk_cnt_o  = blk_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_multiblock_fsm.sv
`default_nettype none
// ============================================================================
// Module  : tb_aes_multiblock_fsm
// Purpose : Self-checking bench for aes_multiblock_fsm. Streamers and engine
//           are modelled by the bench; expected addresses, counts, errors and
//           done timing come from the job parameters the bench chose.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_multiblock_fsm;

  localparam int ADDR_W        = 32;
  localparam int BLK_BYTES     = 16;
  localparam int WORDS_PER_BLK = 4;
  localparam int NBLK_W        = 16;
  localparam int TMO_W         = 12;
  localparam int TMO_CYC       = 1 << TMO_W;
  localparam int BUDGET        = 20000;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              clear = 1'b0;
  logic              start_i = 1'b0;
  logic [NBLK_W-1:0] n_blocks_i = '0;
  logic [1:0]        key_len_i = '0;
  logic [ADDR_W-1:0] src_base_i = '0;
  logic [ADDR_W-1:0] dst_base_i = '0;
  logic              src_ready_i = 1'b0;
  logic              snk_ready_i = 1'b0;
  logic              eng_done_i = 1'b0;
  logic              src_req_o, snk_req_o;
  logic [ADDR_W-1:0] src_addr_o, dst_addr_o;
  logic [15:0]       line_len_o;
  logic              eng_start_o, eng_enable_o, eng_clear_o;
  logic [3:0]        rounds_o;
  logic              busy_o, done_o;
  logic [1:0]        error_o;
  logic [NBLK_W-1:0] blk_cnt_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_multiblock_fsm #(
    .ADDR_W(ADDR_W), .BLK_BYTES(BLK_BYTES), .WORDS_PER_BLK(WORDS_PER_BLK),
    .NBLK_W(NBLK_W), .TMO_W(TMO_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .start_i(start_i),
    .n_blocks_i(n_blocks_i), .key_len_i(key_len_i),
    .src_base_i(src_base_i), .dst_base_i(dst_base_i),
    .src_ready_i(src_ready_i), .snk_ready_i(snk_ready_i),
    .eng_done_i(eng_done_i),
    .src_req_o(src_req_o), .snk_req_o(snk_req_o),
    .src_addr_o(src_addr_o), .dst_addr_o(dst_addr_o),
    .line_len_o(line_len_o), .eng_start_o(eng_start_o),
    .eng_enable_o(eng_enable_o), .eng_clear_o(eng_clear_o),
    .rounds_o(rounds_o), .busy_o(busy_o), .done_o(done_o),
    .error_o(error_o), .blk_cnt_o(blk_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_rounds(input int key);
    return (key == 3) ? 4'd0 : 4'(10 + 2 * key);
  endfunction

  // Issue a start pulse with the given config, then scramble the config
  // inputs so that anything not latched on the start cycle shows up.
  task automatic start_job(input int n, input int key, input logic [31:0] src, input logic [31:0] dst);
    @(negedge clk);
    start_i    = 1'b1;
    n_blocks_i = NBLK_W'(n);
    key_len_i  = 2'(key);
    src_base_i = src;
    dst_base_i = dst;
    @(negedge clk);
    start_i    = 1'b0;
    n_blocks_i = NBLK_W'($urandom);
    key_len_i  = 2'($urandom);
    src_base_i = $urandom;
    dst_base_i = $urandom;
  endtask

  // One complete job. rdy_mode 0: readies always high; 1: random readies,
  // stray eng_done and stray start pulses. withhold: engine never finishes.
  task automatic run_job(input int n, input int key, input logic [31:0] src, input logic [31:0] dst,
                         input int lat, input int rdy_mode, input bit withhold);
    int  cyc, reqs, ecnt, exp_reqs, exp_blk, exp_err, exp_done;
    bit  prev_req, done_seen;
    logic [31:0] ea_src, ea_dst;

    exp_reqs = (key == 3) ? 0 : n;
    exp_blk  = (key == 3 || withhold) ? 0 : n;
    exp_err  = (key == 3) ? 1 : ((withhold && n > 0) ? 2 : 0);
    // Cycle index of done_o counted from the start cycle (0).
    if (key == 3 || n == 0)      exp_done = 2;
    else if (withhold)           exp_done = 3 + TMO_CYC;          // only used with n=1
    else if (rdy_mode == 0)      exp_done = 1 + n * (lat + 2);    // CHECK + n*(START+lat WORK) + (n-1) NEXT + FIN
    else                         exp_done = -1;

    src_ready_i = (rdy_mode == 0);
    snk_ready_i = (rdy_mode == 0);
    start_job(n, key, src, dst);

    cyc = 1; reqs = 0; ecnt = 0; prev_req = 0; done_seen = 0;
    while (!done_seen && cyc < BUDGET) begin
      eng_done_i = 1'b0;
      if (ecnt > 0) begin
        ecnt--;
        if (ecnt == 0) eng_done_i = 1'b1;
      end
      if (rdy_mode == 1) begin
        src_ready_i = 1'($urandom);
        snk_ready_i = 1'($urandom);
        start_i     = ($urandom_range(0, 7) == 0);
        if (src_req_o && ($urandom_range(0, 2) == 0)) eng_done_i = 1'b1;
      end
      if (src_req_o && src_ready_i && snk_ready_i && !withhold) ecnt = lat;

      if (src_req_o && !prev_req) begin
        ea_src = src + 32'(reqs * BLK_BYTES);
        ea_dst = dst + 32'(reqs * BLK_BYTES);
        check("src_addr", 64'(src_addr_o), 64'(ea_src));
        check("dst_addr", 64'(dst_addr_o), 64'(ea_dst));
        check("req_pair", {snk_req_o, eng_start_o, eng_enable_o}, 3'b111);
        check("rounds_blk", 64'(rounds_o), 64'(model_rounds(key)));
        reqs++;
      end
      prev_req = src_req_o;

      if (done_o) begin
        done_seen = 1;
        if (exp_done >= 0) check("done_cycle", 64'(cyc), 64'(exp_done));
        check("busy_at_done", 64'(busy_o), 64'd1);
        check("eng_en_at_done", 64'(eng_enable_o), 64'd0);
        check("blk_cnt", 64'(blk_cnt_o), 64'(exp_blk));
        check("error", 64'(error_o), 64'(exp_err));
        check("rounds_done", 64'(rounds_o), 64'(model_rounds(key)));
      end
      @(negedge clk);
      cyc++;
    end
    start_i = 1'b0; eng_done_i = 1'b0;
    check("done_seen", 64'(done_seen), 64'd1);
    check("req_count", 64'(reqs), 64'(exp_reqs));
    // One cycle after FINISHED: back in IDLE with results held.
    check("idle_after", {busy_o, done_o, eng_clear_o}, 3'b001);
    check("blk_hold", 64'(blk_cnt_o), 64'(exp_blk));
    check("err_hold", 64'(error_o), 64'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    int n, key, lat, mode;
    logic [31:0] s, d;
    bit any_done;

    // Reset values
    #12;
    check("rst_outs", {src_req_o, snk_req_o, eng_start_o, eng_enable_o, busy_o, done_o}, 6'b0);
    check("rst_clear", 64'(eng_clear_o), 64'd1);
    check("rst_linelen", 64'(line_len_o), 64'(WORDS_PER_BLK));
    check("rst_regs", {src_addr_o, dst_addr_o, rounds_o, error_o, blk_cnt_o}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed jobs
    run_job(3, 0, 32'h1000, 32'h2000, 10, 0, 0);
    run_job(1, 3, 32'h1000, 32'h2000, 5, 0, 0);
    run_job(0, 1, 32'h1000, 32'h2000, 5, 0, 0);
    run_job(2, 2, 32'hFFFF_FFF0, 32'hFFFF_FFE0, 3, 0, 0);
    run_job(1, 0, 32'h4000, 32'h5000, 0, 0, 1);            // timeout
    run_job(1, 1, 32'h4000, 32'h5000, TMO_CYC, 0, 0);      // done on timeout cycle

    // One ready alone never starts the block
    src_ready_i = 1'b0; snk_ready_i = 1'b0;
    start_job(1, 1, 32'h100, 32'h200);
    @(negedge clk);                                         // STARTING
    src_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("partial_wait", {src_req_o, snk_req_o, busy_o}, 3'b111);
    end
    snk_ready_i = 1'b1;
    @(negedge clk);
    src_ready_i = 1'b0; snk_ready_i = 1'b0;
    check("partial_working", {src_req_o, eng_enable_o}, 2'b01);
    eng_done_i = 1'b1;
    @(negedge clk);
    eng_done_i = 1'b0;
    check("partial_done", {done_o, 2'(error_o), 4'(blk_cnt_o), rounds_o}, {1'b1, 2'd0, 4'd1, 4'd12});
    @(negedge clk);

    // Soft clear in WORKING aborts without done
    src_ready_i = 1'b1; snk_ready_i = 1'b1;
    start_job(3, 2, 32'h3000, 32'h6000);
    @(negedge clk);                                         // STARTING
    @(negedge clk);                                         // WORKING
    check("clr_pre", {busy_o, eng_enable_o, src_req_o}, 3'b110);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_idle", {busy_o, done_o, eng_clear_o}, 3'b001);
    check("clr_regs", {src_addr_o, dst_addr_o, rounds_o, error_o, blk_cnt_o}, '0);
    any_done = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done_o || busy_o) any_done = 1;
    end
    check("clr_no_done", 64'(any_done), 64'd0);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      n    = $urandom_range(0, 4);
      key  = $urandom_range(0, 3);
      lat  = $urandom_range(1, 8);
      mode = $urandom_range(0, 1);
      s    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 + 32'($urandom_range(0, 3) * 16)) : $urandom;
      d    = $urandom;
      run_job(n, key, s, d, lat, mode, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
